// File: rtl/uart_rx_msg.sv
// Command-frame parser: hunts for the 0x5A header, decodes the command, gathers
// operands, verifies CRC8 and only then commits cmd/theta/burst count.
module uart_rx_msg #(
  parameter int unsigned TIMEOUT_CYCLES = 1_000_000,
  parameter logic [7:0]  CRC_POLY       = 8'h9B,
  parameter logic [7:0]  CRC_INIT       = 8'h00
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [7:0]  i_rx_byte,
  input  logic        i_rx_byte_valid,
  output logic [7:0]  o_cmd_reg,
  output logic        o_cmd_valid,
  output logic [7:0]  o_burst_cnt,
  output logic        o_burst_cnt_valid,
  output logic [47:0] o_theta,
  output logic        o_theta_valid,
  output logic        o_cordic_en,
  output logic        o_rx_msg_err
);

  localparam logic [7:0] HDR    = 8'h5A;
  localparam logic [7:0] CMD_D1 = 8'hD1;
  localparam logic [7:0] CMD_D2 = 8'hD2;
  localparam logic [7:0] CMD_E1 = 8'hE1;
  localparam logic [7:0] CMD_E2 = 8'hE2;

  localparam int unsigned   TO_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CMD,
    S_BURST,
    S_THETA,
    S_CRC,
    S_COMMIT
  } state_t;

  state_t          state_q;
  logic [7:0]      crc_q;
  logic [7:0]      cmd_sh_q;
  logic [7:0]      burst_sh_q;
  logic [47:0]     theta_sh_q;
  logic [2:0]      idx_q;
  logic [TO_W-1:0] to_cnt_q;
  logic            burst_pend_q;

  logic [7:0]      crc_base;
  logic [7:0]      crc_d;

  function automatic logic [7:0] crc8_byte(input logic [7:0] crc, input logic [7:0] data);
    logic [7:0] c;
    c = crc ^ data;
    for (int k = 0; k < 8; k++) begin
      c = c[7] ? ((c << 1) ^ CRC_POLY) : (c << 1);
    end
    return c;
  endfunction

  // A header seen in IDLE or COMMIT restarts the running CRC from the preset.
  always_comb begin
    crc_base = crc_q;
    if (state_q == S_IDLE || state_q == S_COMMIT) begin
      crc_base = CRC_INIT;
    end
    crc_d = crc8_byte(crc_base, i_rx_byte);
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q           <= S_IDLE;
      crc_q             <= CRC_INIT;
      cmd_sh_q          <= 8'h00;
      burst_sh_q        <= 8'h00;
      theta_sh_q        <= 48'h0;
      idx_q             <= 3'd0;
      to_cnt_q          <= '0;
      burst_pend_q      <= 1'b0;
      o_cmd_reg         <= 8'h00;
      o_cmd_valid       <= 1'b0;
      o_burst_cnt       <= 8'h00;
      o_burst_cnt_valid <= 1'b0;
      o_theta           <= 48'h0;
      o_theta_valid     <= 1'b0;
      o_cordic_en       <= 1'b0;
      o_rx_msg_err      <= 1'b0;
    end else begin
      o_cmd_valid       <= 1'b0;
      o_theta_valid     <= 1'b0;
      o_burst_cnt_valid <= 1'b0;
      o_rx_msg_err      <= 1'b0;

      // Burst-count pulse trails the commit by one cycle regardless of parser state.
      if (burst_pend_q) begin
        o_burst_cnt_valid <= 1'b1;
        burst_pend_q      <= 1'b0;
      end

      if (i_rx_byte_valid) begin
        to_cnt_q <= '0;
      end else if (state_q != S_IDLE && state_q != S_COMMIT) begin
        if (to_cnt_q == TO_LAST) begin
          o_rx_msg_err <= 1'b1;
          state_q      <= S_IDLE;
          to_cnt_q     <= '0;
        end else begin
          to_cnt_q <= to_cnt_q + 1'b1;
        end
      end

      if (state_q == S_COMMIT) begin
        o_cmd_reg   <= cmd_sh_q;
        o_cmd_valid <= 1'b1;
        if (cmd_sh_q == CMD_D1 || cmd_sh_q == CMD_D2) begin
          o_theta       <= theta_sh_q;
          o_theta_valid <= 1'b1;
        end
        if (cmd_sh_q == CMD_D2) begin
          o_burst_cnt  <= burst_sh_q;
          burst_pend_q <= 1'b1;
        end
        if (cmd_sh_q == CMD_E2) begin
          o_cordic_en <= 1'b1;
        end else if (cmd_sh_q == CMD_E1) begin
          o_cordic_en <= 1'b0;
        end
      end

      case (state_q)
        S_IDLE, S_COMMIT: begin
          state_q <= S_IDLE;
          if (i_rx_byte_valid && i_rx_byte == HDR) begin
            state_q <= S_CMD;
            crc_q   <= crc_d;
          end
        end
        S_CMD: begin
          if (i_rx_byte_valid) begin
            cmd_sh_q <= i_rx_byte;
            crc_q    <= crc_d;
            idx_q    <= 3'd0;
            if (i_rx_byte == CMD_D1) begin
              state_q <= S_THETA;
            end else if (i_rx_byte == CMD_D2) begin
              state_q <= S_BURST;
            end else if (i_rx_byte == CMD_E1 || i_rx_byte == CMD_E2) begin
              state_q <= S_CRC;
            end else begin
              o_rx_msg_err <= 1'b1;
              state_q      <= S_IDLE;
            end
          end
        end
        S_BURST: begin
          if (i_rx_byte_valid) begin
            if (i_rx_byte == 8'h00) begin
              o_rx_msg_err <= 1'b1;
              state_q      <= S_IDLE;
            end else begin
              burst_sh_q <= i_rx_byte;
              crc_q      <= crc_d;
              idx_q      <= 3'd0;
              state_q    <= S_THETA;
            end
          end
        end
        S_THETA: begin
          if (i_rx_byte_valid) begin
            theta_sh_q[{idx_q, 3'b000} +: 8] <= i_rx_byte;
            crc_q <= crc_d;
            if (idx_q == 3'd5) begin
              state_q <= S_CRC;
            end else begin
              idx_q <= idx_q + 3'd1;
            end
          end
        end
        S_CRC: begin
          if (i_rx_byte_valid) begin
            if (i_rx_byte == crc_q) begin
              state_q <= S_COMMIT;
            end else begin
              o_rx_msg_err <= 1'b1;
              state_q      <= S_IDLE;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule
